// File: rtl/registro_alarma_if.sv
// Bus between the setup-time watcher / report logic and the alarm logger.
// Carries the sampled alarm, the control strobes and the registered log outputs.
interface registro_alarma_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned TS_W  = 16
);
   logic             Alarm;
   logic             Ack;
   logic             Clr;
   logic [CNT_W-1:0] Violations;
   logic [TS_W-1:0]  FirstTS;
   logic [TS_W-1:0]  LastTS;
   logic             Valid;
   logic             Fault;
   logic [1:0]       State;

   modport master (
      output Alarm, Ack, Clr,
      input  Violations, FirstTS, LastTS, Valid, Fault, State
   );

   modport slave (
      input  Alarm, Ack, Clr,
      output Violations, FirstTS, LastTS, Valid, Fault, State
   );
endinterface

// File: rtl/registro_alarma.sv
// Logs setup-violation alarms (saturating count, first/last cycle stamps) and
// raises a sticky fault after BURST consecutive violating samples.
module registro_alarma #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned TS_W  = 16,
   parameter int unsigned BURST = 4
) (
   input  logic                CLK,
   input  logic                RST,
   registro_alarma_if.slave    bus
);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ALERTA = 2'd1,
      FALLA  = 2'd2
   } estado_e;

   localparam logic [7:0] BURST_C = 8'(BURST);

   logic [TS_W-1:0]  tiempo_q, tiempo_d;
   logic [TS_W-1:0]  first_q, first_d;
   logic [TS_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0] viol_q, viol_d;
   logic             valid_q, valid_d;

   estado_e          estado_q;
   logic [7:0]       racha_q;
   logic             fault_q;

   // Clear is applied first so a same-cycle alarm becomes the first new entry.
   always_comb begin
      tiempo_d = tiempo_q + 1'b1;
      viol_d   = viol_q;
      first_d  = first_q;
      last_d   = last_q;
      valid_d  = valid_q;
      if (bus.Clr) begin
         viol_d  = '0;
         first_d = '0;
         last_d  = '0;
         valid_d = 1'b0;
      end
      if (bus.Alarm) begin
         if (viol_d != '1) viol_d = viol_d + 1'b1;
         last_d = tiempo_q;
         if (!valid_d) begin
            first_d = tiempo_q;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tiempo_q <= '0;
         viol_q   <= '0;
         first_q  <= '0;
         last_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         tiempo_q <= tiempo_d;
         viol_q   <= viol_d;
         first_q  <= first_d;
         last_q   <= last_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         estado_q <= REPOSO;
         racha_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         case (estado_q)
            REPOSO: begin
               fault_q <= 1'b0;
               if (bus.Alarm) begin
                  estado_q <= ALERTA;
                  racha_q  <= 8'd1;
               end else begin
                  racha_q  <= '0;
               end
            end
            ALERTA: begin
               if (bus.Alarm) begin
                  racha_q <= racha_q + 8'd1;
                  if (racha_q + 8'd1 == BURST_C) begin
                     estado_q <= FALLA;
                     fault_q  <= 1'b1;
                  end
               end else begin
                  estado_q <= REPOSO;
                  racha_q  <= '0;
               end
            end
            FALLA: begin
               if (bus.Ack) begin
                  estado_q <= REPOSO;
                  racha_q  <= '0;
                  fault_q  <= 1'b0;
               end
            end
            default: begin
               estado_q <= REPOSO;
               racha_q  <= '0;
               fault_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Violations = viol_q;
   assign bus.FirstTS    = first_q;
   assign bus.LastTS     = last_q;
   assign bus.Valid      = valid_q;
   assign bus.Fault      = fault_q;
   assign bus.State      = estado_q;

endmodule

// File: tb/tb_registro_alarma.sv
// Drives two loggers (wide and narrow counters/timestamps) with shared stimulus
// and compares every output after each edge against a behavioural model.
module tb_registro_alarma;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic alarm = 1'b0;
   logic ack = 1'b0;
   logic clr = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   registro_alarma_if #(.CNT_W(8), .TS_W(16)) bus_a ();
   registro_alarma_if #(.CNT_W(4), .TS_W(4))  bus_b ();

   assign bus_a.Alarm = alarm;
   assign bus_a.Ack   = ack;
   assign bus_a.Clr   = clr;
   assign bus_b.Alarm = alarm;
   assign bus_b.Ack   = ack;
   assign bus_b.Clr   = clr;

   registro_alarma #(.CNT_W(8), .TS_W(16), .BURST(4)) dut_a (
      .CLK (clk),
      .RST (rst),
      .bus (bus_a.slave)
   );

   registro_alarma #(.CNT_W(4), .TS_W(4), .BURST(4)) dut_b (
      .CLK (clk),
      .RST (rst),
      .bus (bus_b.slave)
   );

   // Model state, index 0 = wide instance, 1 = narrow instance
   localparam int BURST_M = 4;
   int cw [2] = '{8, 4};
   int tw [2] = '{16, 4};
   int m_t [2];
   int m_v [2];
   int m_f [2];
   int m_l [2];
   int m_valid [2];
   int m_fault [2];
   int m_run [2];

   function automatic void model_update(input bit r, input bit a, input bit k, input bit c);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            m_t[i] = 0; m_v[i] = 0; m_f[i] = 0; m_l[i] = 0;
            m_valid[i] = 0; m_fault[i] = 0; m_run[i] = 0;
         end else begin
            int stamp;
            stamp = m_t[i];
            m_t[i] = (m_t[i] + 1) % (1 << tw[i]);
            if (c) begin
               m_v[i] = 0; m_f[i] = 0; m_l[i] = 0; m_valid[i] = 0;
            end
            if (a) begin
               if (m_v[i] < (1 << cw[i]) - 1) m_v[i]++;
               m_l[i] = stamp;
               if (m_valid[i] == 0) begin
                  m_f[i] = stamp;
                  m_valid[i] = 1;
               end
            end
            if (m_fault[i] != 0) begin
               if (k) begin
                  m_fault[i] = 0;
                  m_run[i] = 0;
               end
            end else if (a) begin
               m_run[i]++;
               if (m_run[i] >= BURST_M) m_fault[i] = 1;
            end else begin
               m_run[i] = 0;
            end
         end
      end
   endfunction

   function automatic int exp_state(input int i);
      if (m_fault[i] != 0) return 2;
      return (m_run[i] > 0) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a_viol",  int'(bus_a.Violations), m_v[0]);
      chk("a_first", int'(bus_a.FirstTS),    m_f[0]);
      chk("a_last",  int'(bus_a.LastTS),     m_l[0]);
      chk("a_valid", int'(bus_a.Valid),      m_valid[0]);
      chk("a_fault", int'(bus_a.Fault),      m_fault[0]);
      chk("a_state", int'(bus_a.State),      exp_state(0));
      chk("b_viol",  int'(bus_b.Violations), m_v[1]);
      chk("b_first", int'(bus_b.FirstTS),    m_f[1]);
      chk("b_last",  int'(bus_b.LastTS),     m_l[1]);
      chk("b_valid", int'(bus_b.Valid),      m_valid[1]);
      chk("b_fault", int'(bus_b.Fault),      m_fault[1]);
      chk("b_state", int'(bus_b.State),      exp_state(1));
   endtask

   task automatic step(input bit r, input bit a, input bit k, input bit c);
      rst = r; alarm = a; ack = k; clr = c;
      @(posedge clk);
      model_update(r, a, k, c);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic alarms(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int ts;
      // Reset held two cycles with Alarm high
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("rst_state", int'(bus_a.State), 0);
      chk("rst_viol",  int'(bus_a.Violations), 0);

      // Single violation at stamp 10
      idle(10);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("single_viol",  int'(bus_a.Violations), 1);
      chk("single_first", int'(bus_a.FirstTS), 10);
      chk("single_last",  int'(bus_a.LastTS), 10);
      chk("single_state", int'(bus_a.State), 1);
      idle(1);
      chk("single_back", int'(bus_a.State), 0);

      // Burst of 4 from stamp 20
      idle(8);
      alarms(3);
      chk("burst3_fault", int'(bus_a.Fault), 0);
      alarms(1);
      chk("burst_fault", int'(bus_a.Fault), 1);
      chk("burst_state", int'(bus_a.State), 2);
      chk("burst_last",  int'(bus_a.LastTS), 23);
      idle(3);
      chk("burst_hold", int'(bus_a.Fault), 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("burst_ack", int'(bus_a.State), 0);

      // 3, gap, 3 never faults
      alarms(3); idle(1); alarms(3);
      chk("run3_nofault", int'(bus_a.Fault), 0);
      idle(1);

      // Ack/Alarm collision in FALLA
      alarms(4);
      ts = m_v[0];
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("coll_state", int'(bus_a.State), 0);
      chk("coll_viol",  int'(bus_a.Violations), ts + 1);
      alarms(3);
      chk("coll_alerta", int'(bus_a.State), 1);
      chk("coll_nofault", int'(bus_a.Fault), 0);
      alarms(1);
      chk("coll_refault", int'(bus_a.Fault), 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      // Saturation on the narrow counter, then Clr with Alarm
      alarms(20);
      chk("sat_b", int'(bus_b.Violations), 15);
      ts = m_t[0];
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("clr_viol_a",  int'(bus_a.Violations), 1);
      chk("clr_viol_b",  int'(bus_b.Violations), 1);
      chk("clr_first_a", int'(bus_a.FirstTS), ts);
      chk("clr_last_a",  int'(bus_a.LastTS), ts);

      // Reset while in FALLA
      chk("pre_rst_fault", int'(bus_a.Fault), 1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("midrst_fault", int'(bus_a.Fault), 0);
      chk("midrst_valid", int'(bus_a.Valid), 0);

      // Timestamp wrap on the narrow instance
      idle(14);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("wrap_first", int'(bus_b.FirstTS), 14);
      chk("wrap_last",  int'(bus_b.LastTS), 2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit r, a, k, c;
         r = ($urandom_range(99, 0) < 1);
         a = ($urandom_range(99, 0) < 65);
         k = ($urandom_range(99, 0) < 15);
         c = ($urandom_range(99, 0) < 5);
         step(r, a, k, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/registro_alarma.md
# registro_alarma

Downstream consumer of the flip-flop setup-time watcher's `Alarm` output. Samples `Alarm` on every rising `CLK` and keeps a saturating count of violating cycles and cycle-stamps of the first and last violation. A burst FSM raises a sticky `Fault` when `BURST` consecutive violations occur. Sits between the watcher and the bench/report logic, which reads the log and acknowledges faults.

## Interface
Parameters:
- `CNT_W`, 8: width of the violation counter.
- `TS_W`, 16: width of the free-running cycle timestamp.
- `BURST`, 4: consecutive violating cycles that trigger `Fault`; legal range 2..255.

Ports:
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `Alarm`  in  1  setup-violation flag from the watcher, sampled at each rising `CLK`.
- `Ack`  in  1  fault acknowledge; one-cycle pulse or held level, both legal.
- `Clr`  in  1  clears the log registers; does not touch the FSM.
- `Violations`  out  CNT_W  saturating count of sampled cycles with `Alarm`=1.
- `FirstTS`  out  TS_W  timestamp of the first violation since reset or `Clr`.
- `LastTS`  out  TS_W  timestamp of the most recent violation.
- `Valid`  out  1  at least one violation logged since reset or `Clr`.
- `Fault`  out  1  sticky burst fault; equals (state == FALLA).
- `State`  out  2  FSM state code: REPOSO=0, ALERTA=1, FALLA=2.

## Operation
- Timestamp `Tiempo`, internal, TS_W bits: increments by 1 every cycle and wraps modulo 2^TS_W. `RST` is its only clear; `Clr` does not affect it.
- Stamp of a sample = value of `Tiempo` at that edge, before the increment.
- Logging on a sampled `Alarm`=1:
  - `Violations` increments by 1 and holds at 2^CNT_W−1 once reached.
  - `LastTS` takes the stamp.
  - If `Valid`=0: `FirstTS` takes the stamp and `Valid` goes to 1.
- `Clr`=1: `Violations`, `FirstTS`, `LastTS` and `Valid` clear to 0.
  - If `Alarm`=1 in the same cycle, that sample is logged as the first entry after the clear: `Violations`=1, `FirstTS`=`LastTS`=stamp, `Valid`=1.
- Burst FSM, with run counter `racha` that saturates at `BURST`:
  - REPOSO: `Alarm`=1 → ALERTA with `racha`=1. Otherwise stay, with `racha`=0.
  - ALERTA: `Alarm`=1 → `racha`+1; on reaching `BURST`, go to FALLA. `Alarm`=0 → REPOSO with `racha`=0.
  - FALLA: sticky regardless of `Alarm`. `Ack`=1 → REPOSO with `racha`=0.
  - `Ack` in REPOSO or ALERTA is ignored.
  - State code 3 is illegal and recovers to REPOSO on the next edge.
- `Ack` and `Alarm` in the same FALLA cycle: `Ack` wins, next state is REPOSO with `racha`=0. The sample is still logged. A new burst needs `BURST` further consecutive samples.
- Logging is independent of the FSM state; counting continues during FALLA.

## Timing
- Reset (`RST`=1 at an edge): all outputs 0, `State`=REPOSO, `Tiempo`=0, `racha`=0. `RST` overrides `Clr`, `Ack` and `Alarm`.
- Reset mid-operation, including in FALLA, clears everything on that edge. No residue remains afterwards.
- Latency: an `Alarm` value sampled at edge k is reflected on all outputs immediately after edge k. All outputs are registered, with no combinational input-to-output path.
- The watcher updates `Alarm` nonblocking on the same edge, so a violation detected at edge k is sampled here at edge k+1. Total pipeline delay from violating clock edge to log is 1 cycle.
- `Fault` rises after the edge carrying the `BURST`-th consecutive `Alarm`=1 sample.
- `Fault` falls after the first edge with `Ack`=1 while in FALLA.
- Timestamp wrap: after 2^TS_W−1 the next stamp is 0. `FirstTS` may exceed `LastTS`, and this is legal.

## Test plan
- Reset: hold `RST` 2 cycles with `Alarm`=1, then release with `Alarm`=0 → all outputs 0, `State`=0; `Tiempo`=0 at the first edge after release.
- Single violation: `Alarm`=1 for one sample at `Tiempo`=10 → `Violations`=1, `FirstTS`=`LastTS`=10, `Valid`=1, `State`=1 then 0, `Fault`=0.
- Burst: `Alarm`=1 for 4 consecutive samples from `Tiempo`=20 → `State`=2 and `Fault`=1 after the 4th edge, `LastTS`=23; `Fault` holds with `Alarm`=0 until `Ack`, then `State`=0. A run of 3, then a gap, then 3 never faults.
- Ack/Alarm collision in FALLA → `State`=0, `Violations` increments; 3 more alarms give `State`=1 and no fault; a 4th gives `Fault`=1.
- Saturation and Clr: `CNT_W`=4 with 20 alarm samples → `Violations`=15. Then `Clr` together with `Alarm`=1 at `Tiempo`=T → `Violations`=1, `FirstTS`=`LastTS`=T.
- Wrap: `TS_W`=4, first alarm at stamp 14, second at stamp 2 (after wrap) → `FirstTS`=14, `LastTS`=2.
